// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: R/W bit encoding, frame FSM
// state type and helpers that size the frame and the bit counter.
package spi_pkg;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ADDR    = 2'd1,
      ST_DATA    = 2'd2,
      ST_OVERRUN = 2'd3
   } spi_state_e;

   // Total frame length: R/W bit + address + data.
   function automatic int unsigned calc_frame_w(input int unsigned addr_w,
                                                input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

   // Counter must reach FRAME_W+1 (overrun saturation value).
   function automatic int unsigned calc_cnt_w(input int unsigned addr_w,
                                              input int unsigned data_w);
      return $clog2(calc_frame_w(addr_w, data_w) + 2);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third registered copy for edge detection.
// Ports: clk/rst_n, d_i asynchronous input, q_o synchronised level,
//        rise_c_o / fall_c_o single-cycle edge indications.
module spi_sync_edge #(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_c_o,
   output logic fall_c_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain plus the delayed copy used for edge compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_LEVEL;
         sync_q <= RESET_LEVEL;
         prev_q <= RESET_LEVEL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o      = sync_q;
   assign rise_c_o = sync_q & ~prev_q;
   assign fall_c_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI register bank: write/read frames of {R/W, address, data}, MSB first,
// into a bank of NUM_REGS registers living in the clk domain.
// Ports: clk/rst_n; sclk_in, ncs_in, copi_in asynchronous SPI pins;
//        cipo_out/cipo_oe read-back data and pad enable; regs_out flattened
//        registers; wr_strobe per-register update pulse; frame_err dropped
//        frame pulse; busy while synchronised NCS is low.
module spi_reg_bank
   import spi_pkg::*;
#(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 5,
   parameter bit          CPOL     = 1'b0,
   parameter bit          CPHA     = 1'b0,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk_in,
   input  logic                       ncs_in,
   input  logic                       copi_in,
   output logic                       cipo_out,
   output logic                       cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_out,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err,
   output logic                       busy
);

   localparam int unsigned FRAME_W = calc_frame_w(ADDR_W, DATA_W);
   localparam int unsigned CNT_W   = calc_cnt_w(ADDR_W, DATA_W);
   localparam int unsigned REGS_W  = NUM_REGS * DATA_W;
   localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(1 + ADDR_W);
   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
   localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

   // ---------------- synchronisers ----------------
   logic sclk_rise, sclk_fall, unused_sclk_lvl;
   logic ncs_s, ncs_rise, ncs_fall;
   logic copi_s, unused_copi_rise, unused_copi_fall;

   spi_sync_edge #(.RESET_LEVEL(CPOL)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(sclk_in),
      .q_o(unused_sclk_lvl), .rise_c_o(sclk_rise), .fall_c_o(sclk_fall)
   );

   spi_sync_edge #(.RESET_LEVEL(1'b1)) u_sync_ncs (
      .clk(clk), .rst_n(rst_n), .d_i(ncs_in),
      .q_o(ncs_s), .rise_c_o(ncs_rise), .fall_c_o(ncs_fall)
   );

   spi_sync_edge #(.RESET_LEVEL(1'b0)) u_sync_copi (
      .clk(clk), .rst_n(rst_n), .d_i(copi_in),
      .q_o(copi_s), .rise_c_o(unused_copi_rise), .fall_c_o(unused_copi_fall)
   );

   // Leading edge leaves the idle level; CPHA picks which edge samples.
   logic lead_edge, trail_edge, sample_edge, shift_edge;
   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge  : trail_edge;

   // ---------------- state ----------------
   spi_state_e                  state_q, state_d;
   logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]          rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0]           tx_shift_q, tx_shift_d;
   logic                        cipo_oe_q, cipo_oe_d;
   logic [REGS_W-1:0]           regs_q, regs_d;
   logic [NUM_REGS-1:0]         wr_strobe_q, wr_strobe_d;
   logic                        frame_err_q, frame_err_d;

   logic frame_act_c, overrun_c, sample_c, shift_c;
   logic commit_c, err_c;

   // Header view (valid at bit_count == 1+ADDR_W) and full-frame view.
   logic              hdr_rw;
   logic [ADDR_W-1:0] hdr_addr;
   logic              fr_rw;
   logic [ADDR_W-1:0] fr_addr;
   logic [DATA_W-1:0] fr_data;
   logic [DATA_W-1:0] rd_data_c;

   assign hdr_rw   = rx_shift_q[ADDR_W];
   assign hdr_addr = rx_shift_q[ADDR_W-1:0];
   assign fr_rw    = rx_shift_q[FRAME_W-1];
   assign fr_addr  = rx_shift_q[FRAME_W-2 -: ADDR_W];
   assign fr_data  = rx_shift_q[DATA_W-1:0];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; NCS rising always returns to IDLE.
   always_comb begin
      state_d = state_q;
      if (ncs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (ncs_fall) state_d = ST_ADDR;
            ST_ADDR:    if (bit_cnt_q == CNT_HDR) state_d = ST_DATA;
            ST_DATA:    if (sample_c && (bit_cnt_q == CNT_FULL)) state_d = ST_OVERRUN;
            default:    ;
         endcase
      end
   end

   // FSM outputs; an SCLK edge coincident with NCS rising is ignored.
   always_comb begin
      frame_act_c = 1'b0;
      overrun_c   = 1'b0;
      case (state_q)
         ST_ADDR, ST_DATA: frame_act_c = ~ncs_s & ~ncs_rise;
         ST_OVERRUN: begin
            frame_act_c = ~ncs_s & ~ncs_rise;
            overrun_c   = 1'b1;
         end
         default: ;
      endcase
   end

   assign sample_c = sample_edge & frame_act_c;
   assign shift_c  = shift_edge & frame_act_c & ~overrun_c;

   // End-of-frame decisions, taken on the synchronised NCS rising edge.
   assign commit_c = ncs_rise && (state_q != ST_OVERRUN) && (bit_cnt_q == CNT_FULL)
                     && (fr_rw == RW_WRITE) && ({1'b0, fr_addr} < ADDR_LIM);
   assign err_c    = ncs_rise && ((state_q == ST_OVERRUN)
                     || ((bit_cnt_q != CNT_FULL) && (bit_cnt_q != '0)));

   // Read-back mux; unimplemented addresses read as zero.
   always_comb begin
      rd_data_c = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (hdr_addr == ADDR_W'(i)) rd_data_c = regs_q[i*DATA_W +: DATA_W];
      end
   end

   // Datapath next-state.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      cipo_oe_d   = cipo_oe_q;
      regs_d      = regs_q;
      wr_strobe_d = '0;
      frame_err_d = err_c;

      if ((state_q == ST_IDLE) && ncs_fall) begin
         bit_cnt_d  = '0;
         rx_shift_d = '0;
      end

      if (sample_c) begin
         if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_W'(1);
         if (!overrun_c) rx_shift_d = {rx_shift_q[FRAME_W-2:0], copi_s};
      end

      // First shift edge after the header loads read data; later ones shift.
      if (shift_c) begin
         if (!cipo_oe_q && (bit_cnt_q == CNT_HDR) && (hdr_rw == RW_READ)) begin
            tx_shift_d = rd_data_c;
            cipo_oe_d  = 1'b1;
         end else if (cipo_oe_q) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
         end
      end

      // Clearing tx_shift with the enable keeps cipo_out low when not driven.
      if (ncs_rise || overrun_c) begin
         cipo_oe_d  = 1'b0;
         tx_shift_d = '0;
      end

      if (commit_c) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (fr_addr == ADDR_W'(i)) begin
               regs_d[i*DATA_W +: DATA_W] = fr_data;
               wr_strobe_d[i]             = 1'b1;
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         cipo_oe_q   <= 1'b0;
         regs_q      <= RESET_VAL;
         wr_strobe_q <= '0;
         frame_err_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         cipo_oe_q   <= cipo_oe_d;
         regs_q      <= regs_d;
         wr_strobe_q <= wr_strobe_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign cipo_out  = tx_shift_q[DATA_W-1];
   assign cipo_oe   = cipo_oe_q;
   assign regs_out  = regs_q;
   assign wr_strobe = wr_strobe_q;
   assign frame_err = frame_err_q;
   assign busy      = ~ncs_s;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: one instance per SPI mode (index = {CPOL,CPHA}).
module tb_spi_reg_bank;

   localparam int H = 80;   // SCLK half period: 8 clk cycles
   localparam logic [39:0] RV = 40'h11_22_33_44_55;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        sclk [4];
   logic        ncs  [4];
   logic        copi [4];
   logic        cipo [4];
   logic        oe   [4];
   logic        ferr [4];
   logic        busy [4];
   logic [39:0] regs [4];
   logic [4:0]  strb [4];

   spi_reg_bank u_dut0 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk[0]), .ncs_in(ncs[0]), .copi_in(copi[0]),
      .cipo_out(cipo[0]), .cipo_oe(oe[0]), .regs_out(regs[0]), .wr_strobe(strb[0]),
      .frame_err(ferr[0]), .busy(busy[0]));
   spi_reg_bank #(.CPOL(1'b0), .CPHA(1'b1), .RESET_VAL(RV)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk[1]), .ncs_in(ncs[1]), .copi_in(copi[1]),
      .cipo_out(cipo[1]), .cipo_oe(oe[1]), .regs_out(regs[1]), .wr_strobe(strb[1]),
      .frame_err(ferr[1]), .busy(busy[1]));
   spi_reg_bank #(.CPOL(1'b1), .CPHA(1'b0), .RESET_VAL(RV)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk[2]), .ncs_in(ncs[2]), .copi_in(copi[2]),
      .cipo_out(cipo[2]), .cipo_oe(oe[2]), .regs_out(regs[2]), .wr_strobe(strb[2]),
      .frame_err(ferr[2]), .busy(busy[2]));
   spi_reg_bank #(.CPOL(1'b1), .CPHA(1'b1), .RESET_VAL(RV)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .sclk_in(sclk[3]), .ncs_in(ncs[3]), .copi_in(copi[3]),
      .cipo_out(cipo[3]), .cipo_oe(oe[3]), .regs_out(regs[3]), .wr_strobe(strb[3]),
      .frame_err(ferr[3]), .busy(busy[3]));

   // Pulse monitors: cycle counts and the last non-zero strobe pattern.
   int         strb_cyc [4] = '{default: 0};
   int         ferr_cyc [4] = '{default: 0};
   logic [4:0] strb_last[4] = '{default: 5'h0};
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (strb[k] != 5'h0) begin
            strb_cyc[k]++;
            strb_last[k] = strb[k];
         end
         if (ferr[k]) ferr_cyc[k]++;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One SPI transfer as controller; frame bits are fr[nbits-1:0], MSB first.
   task automatic xfer(input int m, input int nbits, input logic [31:0] fr,
                       input bit coincide, input bit hold_sel,
                       output logic [7:0] rd, output logic oe_mid, output logic busy_mid);
      logic cpol, cpha;
      cpol = (m >= 2);
      cpha = (m % 2 == 1);
      rd = '0; oe_mid = 1'b0; busy_mid = 1'b0;
      ncs[m] = 1'b0;
      if (!cpha) copi[m] = fr[nbits-1];
      #(H);
      for (int i = 0; i < nbits; i++) begin
         if (cpha) copi[m] = fr[nbits-1-i];
         if (!cpha && i >= 8 && i < 16) rd[15-i] = cipo[m];
         if (!cpha && i == 8) begin oe_mid = oe[m]; busy_mid = busy[m]; end
         sclk[m] = ~cpol;
         #(H);
         if (cpha && i >= 8 && i < 16) rd[15-i] = cipo[m];
         if (cpha && i == 8) begin oe_mid = oe[m]; busy_mid = busy[m]; end
         sclk[m] = cpol;
         if (!cpha && i < nbits-1) copi[m] = fr[nbits-2-i];
         #(H);
      end
      if (!hold_sel) begin
         if (coincide) sclk[m] = ~cpol;
         ncs[m] = 1'b1;
         #(H);
         sclk[m] = cpol;
         #(H);
      end
   endtask

   logic [7:0] rd;
   logic       oe_mid, busy_mid;
   int         s0, f0;

   initial begin
      for (int k = 0; k < 4; k++) begin
         sclk[k] = (k >= 2);
         ncs[k]  = 1'b1;
         copi[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_regs0", regs[0], 40'h0);
      chk("rst_regs1", regs[1], RV);
      chk("rst_oe", oe[0], 1'b0);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_cipo", cipo[0], 1'b0);
      chk("rst_strb", strb[0], 5'h0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Mode 0 write addr 2 = A5
      s0 = strb_cyc[0]; f0 = ferr_cyc[0];
      xfer(0, 16, 32'h82A5, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("w2_regs", regs[0], 40'h00_00_A5_00_00);
      chk("w2_strb_cycles", strb_cyc[0] - s0, 1);
      chk("w2_strb_value", strb_last[0], 5'b00100);
      chk("w2_no_err", ferr_cyc[0] - f0, 0);
      chk("w2_busy_mid", busy_mid, 1'b1);
      chk("w2_busy_after", busy[0], 1'b0);

      // Write addr 4 = 3C, then read it back
      xfer(0, 16, 32'h843C, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("w4_regs", regs[0], 40'h3C_00_A5_00_00);
      chk("rd4_oe_before", oe[0], 1'b0);
      s0 = strb_cyc[0];
      xfer(0, 16, 32'h0400, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("rd4_data", rd, 8'h3C);
      chk("rd4_oe_mid", oe_mid, 1'b1);
      chk("rd4_oe_after", oe[0], 1'b0);
      chk("rd4_cipo_after", cipo[0], 1'b0);
      chk("rd4_no_strb", strb_cyc[0] - s0, 0);
      chk("rd4_regs", regs[0], 40'h3C_00_A5_00_00);

      // 12-bit short write to addr 0
      s0 = strb_cyc[0]; f0 = ferr_cyc[0];
      xfer(0, 12, 32'h80F, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("short_err", ferr_cyc[0] - f0, 1);
      chk("short_no_strb", strb_cyc[0] - s0, 0);
      chk("short_regs", regs[0], 40'h3C_00_A5_00_00);

      // 17-bit overrun write to addr 0
      s0 = strb_cyc[0]; f0 = ferr_cyc[0];
      xfer(0, 17, 32'h101FF, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("ovr_err", ferr_cyc[0] - f0, 1);
      chk("ovr_no_strb", strb_cyc[0] - s0, 0);
      chk("ovr_regs", regs[0], 40'h3C_00_A5_00_00);

      // Write to unimplemented addr 0x10
      s0 = strb_cyc[0]; f0 = ferr_cyc[0];
      xfer(0, 16, 32'h9077, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("oob_no_err", ferr_cyc[0] - f0, 0);
      chk("oob_no_strb", strb_cyc[0] - s0, 0);
      chk("oob_regs", regs[0], 40'h3C_00_A5_00_00);

      // Empty select: NCS pulse with no SCLK
      f0 = ferr_cyc[0];
      xfer(0, 0, 32'h0, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("empty_no_err", ferr_cyc[0] - f0, 0);

      // Modes 1..3: write addr 1 = 5A and read it back
      for (int m = 1; m < 4; m++) begin
         s0 = strb_cyc[m];
         xfer(m, 16, 32'h815A, 1'b0, 1'b0, rd, oe_mid, busy_mid);
         chk($sformatf("m%0d_regs", m), regs[m], 40'h11_22_33_5A_55);
         chk($sformatf("m%0d_strb", m), strb_last[m], 5'b00010);
         chk($sformatf("m%0d_strb_cycles", m), strb_cyc[m] - s0, 1);
         xfer(m, 16, 32'h0100, 1'b0, 1'b0, rd, oe_mid, busy_mid);
         chk($sformatf("m%0d_rd", m), rd, 8'h5A);
         chk($sformatf("m%0d_oe_after", m), oe[m], 1'b0);
      end
      chk("m0_untouched", regs[0], 40'h3C_00_A5_00_00);

      // Reset after 9 bits of a write, select still low
      f0 = ferr_cyc[0];
      xfer(0, 9, 32'h107, 1'b0, 1'b1, rd, oe_mid, busy_mid);
      rst_n = 1'b0;
      @(negedge clk);
      ncs[0] = 1'b1;
      copi[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_regs0", regs[0], 40'h0);
      chk("mid_rst_regs1", regs[1], RV);
      chk("mid_rst_busy", busy[0], 1'b0);
      chk("mid_rst_oe", oe[0], 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      s0 = strb_cyc[0];
      xfer(0, 16, 32'h83C3, 1'b0, 1'b0, rd, oe_mid, busy_mid);
      chk("post_rst_regs", regs[0], 40'h00_C3_00_00_00);
      chk("post_rst_strb", strb_last[0], 5'b01000);
      chk("post_rst_strb_cycles", strb_cyc[0] - s0, 1);
      chk("post_rst_no_err", ferr_cyc[0] - f0, 0);

      // Extra sample edge coincident with NCS rising after 16 bits
      s0 = strb_cyc[0]; f0 = ferr_cyc[0];
      xfer(0, 16, 32'h82E7, 1'b1, 1'b0, rd, oe_mid, busy_mid);
      chk("coin_regs", regs[0], 40'h00_C3_E7_00_00);
      chk("coin_strb", strb_last[0], 5'b00100);
      chk("coin_strb_cycles", strb_cyc[0] - s0, 1);
      chk("coin_no_err", ferr_cyc[0] - f0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
